n2_wb_arbiter: RTL and testbench
================================

Name: n2_wb_arbiter

Overview:
- Shares the single register-file write port among four writeback sources: IDU (jal/rdcycle/maskirq results), EX, LSU and MU.
- Each source feeds a private DEPTH-entry FIFO. A round-robin arbiter drains one entry per cycle into a registered write port.
- Exports a pending-destination mask so the decode-stage scoreboard can stall on registers whose writeback is still queued.

Parameters:
- REGINDEX_BITS, 5, register index width; NREG = 2**REGINDEX_BITS.
- DEPTH, 2, entries per source FIFO; must be a power of two, ≥ 2.

Ports:
- clk, input, 1, clock.
- resetn, input, 1, asynchronous active-low reset.
- wb_v_i, input, 4, per-source write request; bit 0 = IDU, 1 = EX, 2 = LSU, 3 = MU.
- wb_dst_i, input, 4×REGINDEX_BITS, per-source destination index (packed, source 0 in LSBs).
- wb_data_i, input, 4×32, per-source write data (packed).
- wb_rdy_o, output, 4, per-source FIFO not full.
- rf_we_o, output, 1, register-file write enable.
- rf_dst_o, output, REGINDEX_BITS, write index.
- rf_wdata_o, output, 32, write data.
- pend_mask_o, output, NREG, bit r set while any queued entry or the output register targets r.
- ovf_err_o, output, 2, sticky overflow flags for IDU (bit 0) and EX (bit 1).
- busy_o, output, 1, any FIFO non-empty or rf_we_o high.

Behaviour:
- Reset values: rf_we_o = 0, rf_dst_o = 0, rf_wdata_o = 0, ovf_err_o = 0, all FIFOs empty, rr_ptr = 0. With empty FIFOs and rf_we_o = 0: wb_rdy_o = 4'b1111, pend_mask_o = 0, busy_o = 0.
- FIFO per source: read pointer, write pointer and count, DEPTH+1 states.
  - wb_rdy_o[s] = (count[s] != DEPTH), derived only from registered count. A pop in the same cycle does not make a full FIFO ready.
  - Push when wb_v_i[s] & wb_rdy_o[s].
  - Pointers wrap modulo DEPTH.
- x0 filter: a request with dst == 0 is accepted (handshake completes) and discarded. It is not enqueued, count is unchanged, and it never reaches rf_we_o.
- Backpressure contract:
  - LSU and MU must hold valid, dst and data stable while wb_rdy_o is low.
  - IDU and EX cannot stall. If wb_v_i[s] & ~wb_rdy_o[s] & (dst != 0) for s in {0, 1}, the request is dropped and ovf_err_o[s] is set. The flag is cleared only by reset.
- Arbitration, combinational, each cycle:
  - Scan sources rr_ptr, rr_ptr+1, … (mod 4). Grant the first with a non-empty FIFO and pop it.
  - On a grant to s: rr_ptr <= (s+1) mod 4. With no grant, rr_ptr holds.
  - At most one pop per cycle.
- Output register: rf_we_o <= grant_any; rf_dst_o/rf_wdata_o <= granted head entry. When there is no grant, rf_we_o <= 0 and dst/data hold their old value.
- Latency: a request accepted at edge k into an empty FIFO with no contention appears on rf_we_o after edge k+1 (2-cycle).
- Ordering: FIFO order within a source. No ordering guarantee across sources; the scoreboard prevents WAW.
- pend_mask_o: combinational OR over all valid FIFO entries' dst plus (rf_we_o ? rf_dst_o : none). A bit clears the cycle after its write is presented on rf_we_o.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
- Asynchronous reset mid-operation discards all queued entries immediately.

Test Plan:
- Single EX write dst = 5, data 0xDEADBEEF at edge 0:
  - rf_we_o = 1, rf_dst_o = 5, rf_wdata_o = 0xDEADBEEF in the cycle after edge 1.
  - pend_mask_o[5] = 1 from after edge 0 through the rf_we_o cycle, then 0.
- All four sources write in the same cycle to dst 1, 2, 3, 4, rr_ptr = 0:
  - rf_we_o pulses four consecutive cycles with dst 1, 2, 3, 4.
  - Repeating with rr_ptr = 2 yields dst 3, 4, 1, 2.
- Backpressure:
  - LSU issues 3 back-to-back writes (DEPTH = 2) while IDU, EX and MU each keep their FIFOs non-empty.
  - wb_rdy_o[2] drops after 2 accepts. The third is accepted only after an LSU pop. All three LSU writes emerge in order, with no loss.
- Overflow: EX pushes 3 writes in 3 cycles while the arbiter is saturated by the other sources, so the EX FIFO is full on the third push.
  - Third write is dropped and ovf_err_o = 2'b10, sticky until resetn is pulsed low.
- x0 writes:
  - IDU write with dst = 0 → wb_rdy_o stays 1, no rf_we_o pulse, busy_o stays 0, pend_mask_o stays 0.
- Reset mid-operation:
  - With 5 entries queued, assert resetn low asynchronously → rf_we_o = 0, pend_mask_o = 0 and wb_rdy_o = 4'hF immediately.
  - No queued write appears after release.

Source files
------------

// File: rtl/n2_wb_arbiter.sv
// Purpose: shares the register-file write port among IDU/EX/LSU/MU writeback sources through per-source FIFOs and a round-robin drain.
// Latency: 2 cycles from an accepted request into an empty, uncontended FIFO to rf_we_o.
// Backpressure: wb_rdy_o drops while a FIFO is full; LSU/MU hold their request, IDU/EX requests are dropped and flagged in ovf_err_o.
module n2_wb_arbiter #(
    parameter int REGINDEX_BITS = 5,
    parameter int DEPTH         = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [3:0]                 wb_v_i,
    input  logic [4*REGINDEX_BITS-1:0] wb_dst_i,
    input  logic [4*32-1:0]            wb_data_i,
    output logic [3:0]                 wb_rdy_o,
    output logic                       rf_we_o,
    output logic [REGINDEX_BITS-1:0]   rf_dst_o,
    output logic [31:0]                rf_wdata_o,
    output logic [2**REGINDEX_BITS-1:0] pend_mask_o,
    output logic [1:0]                 ovf_err_o,
    output logic                       busy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [REGINDEX_BITS-1:0] dst;
        logic [31:0]              data;
    } wb_entry_t;

    wb_entry_t        fifo_mem [4][DEPTH];
    logic [PTR_W-1:0] rd_ptr   [4];
    logic [PTR_W-1:0] wr_ptr   [4];
    logic [CNT_W-1:0] count    [4];
    logic [PTR_W-1:0] ent_off  [4][DEPTH];

    logic [3:0] dst_nz;
    logic [3:0] not_empty;
    logic [3:0] push;
    logic [3:0] pop;
    logic [1:0] rr_ptr;
    logic [1:0] grant_idx;
    logic [1:0] scan_idx;
    logic       grant_any;
    wb_entry_t  head;

    // Per-source handshake: ready comes only from the registered count; x0 writes complete but never enqueue.
    always_comb begin
        dst_nz    = '0;
        wb_rdy_o  = '0;
        not_empty = '0;
        push      = '0;
        for (int s = 0; s < 4; s++) begin
            dst_nz[s]    = |wb_dst_i[s*REGINDEX_BITS +: REGINDEX_BITS];
            wb_rdy_o[s]  = (count[s] != CNT_W'(DEPTH));
            not_empty[s] = (count[s] != '0);
            push[s]      = wb_v_i[s] & wb_rdy_o[s] & dst_nz[s];
        end
    end

    // Round-robin scan starting at rr_ptr; first non-empty FIFO wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        scan_idx  = rr_ptr;
        for (int i = 0; i < 4; i++) begin
            scan_idx = rr_ptr + 2'(i);
            if (!grant_any && not_empty[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // One-hot pop of the granted source.
    always_comb begin
        pop = '0;
        for (int s = 0; s < 4; s++) begin
            pop[s] = grant_any & (grant_idx == 2'(s));
        end
    end

    assign head = fifo_mem[grant_idx][rd_ptr[grant_idx]];

    // FIFO storage; contents need no reset because validity is tracked by count.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 4; s++) begin
            if (push[s]) begin
                fifo_mem[s][wr_ptr[s]] <= '{dst:  wb_dst_i[s*REGINDEX_BITS +: REGINDEX_BITS],
                                            data: wb_data_i[s*32 +: 32]};
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < 4; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < 4; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
                if (push[s] && !pop[s])
                    count[s] <= count[s] + CNT_W'(1);
                else if (!push[s] && pop[s])
                    count[s] <= count[s] - CNT_W'(1);
            end
        end
    end

    // Sticky overflow for the sources that cannot stall (IDU, EX).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_err_o <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (wb_v_i[s] && !wb_rdy_o[s] && dst_nz[s]) ovf_err_o[s] <= 1'b1;
            end
        end
    end

    // Registered write port and round-robin pointer advance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr     <= '0;
            rf_we_o    <= 1'b0;
            rf_dst_o   <= '0;
            rf_wdata_o <= '0;
        end else begin
            rf_we_o <= grant_any;
            if (grant_any) begin
                rr_ptr     <= grant_idx + 2'd1;
                rf_dst_o   <= head.dst;
                rf_wdata_o <= head.data;
            end
        end
    end

    // Offset of each storage slot from its FIFO head, wrapping at the pointer width.
    always_comb begin
        for (int s = 0; s < 4; s++) begin
            for (int e = 0; e < DEPTH; e++) begin
                ent_off[s][e] = PTR_W'(e) - rd_ptr[s];
            end
        end
    end

    // Pending destinations: every live FIFO slot plus the write being presented.
    always_comb begin
        pend_mask_o = '0;
        for (int s = 0; s < 4; s++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (CNT_W'(ent_off[s][e]) < count[s]) pend_mask_o[fifo_mem[s][e].dst] = 1'b1;
            end
        end
        if (rf_we_o) pend_mask_o[rf_dst_o] = 1'b1;
    end

    assign busy_o = (|not_empty) | rf_we_o;

endmodule

// File: tb/tb_n2_wb_arbiter.sv
// Directed bench for n2_wb_arbiter: checks reset, round-robin order, backpressure,
// overflow, x0 filtering and asynchronous reset with hand-computed expectations.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that point.
module tb_n2_wb_arbiter;

    logic         clk;
    logic         resetn;
    logic [3:0]   wb_v;
    logic [19:0]  wb_dst;
    logic [127:0] wb_data;
    logic [3:0]   wb_rdy;
    logic         rf_we;
    logic [4:0]   rf_dst;
    logic [31:0]  rf_wdata;
    logic [31:0]  pend_mask;
    logic [1:0]   ovf_err;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    n2_wb_arbiter #(.REGINDEX_BITS(5), .DEPTH(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wb_v_i     (wb_v),
        .wb_dst_i   (wb_dst),
        .wb_data_i  (wb_data),
        .wb_rdy_o   (wb_rdy),
        .rf_we_o    (rf_we),
        .rf_dst_o   (rf_dst),
        .rf_wdata_o (rf_wdata),
        .pend_mask_o(pend_mask),
        .ovf_err_o  (ovf_err),
        .busy_o     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] dat(input logic [4:0] d);
        return 32'hC0DE_0000 | {27'd0, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [4:0] d, input logic [31:0] x);
        wb_v[s]            = 1'b1;
        wb_dst[s*5 +: 5]   = d;
        wb_data[s*32 +: 32] = x;
    endtask

    // All four sources write dst 1..4 at once; grants start at source 'first'.
    task automatic all_four(input int first);
        wb_v = '0;
        for (int s = 0; s < 4; s++) drive(s, 5'(s + 1), dat(5'(s + 1)));
        tick();
        wb_v = '0;
        chk("all4_we0", {63'd0, rf_we}, 64'd0);
        chk("all4_pend", {32'd0, pend_mask}, 64'h1E);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("all4_we", {63'd0, rf_we}, 64'd1);
            chk("all4_dst", {59'd0, rf_dst}, 64'(((first + i) % 4) + 1));
        end
        chk("all4_pend_last", {32'd0, pend_mask}, 64'(32'd1 << (((first + 3) % 4) + 1)));
        tick();
        chk("all4_done_we", {63'd0, rf_we}, 64'd0);
        chk("all4_done_busy", {63'd0, busy}, 64'd0);
        chk("all4_done_pend", {32'd0, pend_mask}, 64'd0);
    endtask

    logic [4:0] bp_exp [9];

    initial begin
        resetn  = 1'b0;
        wb_v    = '0;
        wb_dst  = '0;
        wb_data = '0;
        #2;
        chk("rst_we", {63'd0, rf_we}, 64'd0);
        chk("rst_dst", {59'd0, rf_dst}, 64'd0);
        chk("rst_wdata", {32'd0, rf_wdata}, 64'd0);
        chk("rst_rdy", {60'd0, wb_rdy}, 64'hF);
        chk("rst_pend", {32'd0, pend_mask}, 64'd0);
        chk("rst_ovf", {62'd0, ovf_err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Round robin from rr_ptr = 0.
        all_four(0);

        // Single EX write; rr_ptr 0 -> 2 afterwards.
        drive(1, 5'd5, 32'hDEADBEEF);
        tick();
        wb_v = '0;
        chk("single_we0", {63'd0, rf_we}, 64'd0);
        chk("single_pend0", {32'd0, pend_mask}, 64'h20);
        chk("single_busy0", {63'd0, busy}, 64'd1);
        tick();
        chk("single_we", {63'd0, rf_we}, 64'd1);
        chk("single_dst", {59'd0, rf_dst}, 64'd5);
        chk("single_data", {32'd0, rf_wdata}, 64'hDEADBEEF);
        chk("single_pend1", {32'd0, pend_mask}, 64'h20);
        tick();
        chk("single_we2", {63'd0, rf_we}, 64'd0);
        chk("single_pend2", {32'd0, pend_mask}, 64'd0);

        // Round robin from rr_ptr = 2.
        all_four(2);

        // Backpressure on LSU, rr_ptr = 2.
        bp_exp = '{5'd8, 5'd6, 5'd7, 5'd10, 5'd13, 5'd9, 5'd12, 5'd11, 5'd14};
        drive(0, 5'd6, dat(5'd6));
        drive(1, 5'd7, dat(5'd7));
        drive(3, 5'd8, dat(5'd8));
        tick();
        wb_v = '0;
        chk("bp_e0_we", {63'd0, rf_we}, 64'd0);
        drive(0, 5'd9, dat(5'd9));
        drive(1, 5'd12, dat(5'd12));
        drive(2, 5'd10, dat(5'd10));
        drive(3, 5'd13, dat(5'd13));
        tick();
        wb_v = '0;
        chk("bp_e1_dst", {59'd0, rf_dst}, 64'(bp_exp[0]));
        chk("bp_e1_rdy", {60'd0, wb_rdy}, 64'b1100);
        drive(2, 5'd11, dat(5'd11));
        tick();
        wb_v = '0;
        chk("bp_e2_dst", {59'd0, rf_dst}, 64'(bp_exp[1]));
        chk("bp_e2_rdy", {60'd0, wb_rdy}, 64'b1001);
        drive(2, 5'd14, dat(5'd14));
        tick();
        chk("bp_e3_dst", {59'd0, rf_dst}, 64'(bp_exp[2]));
        chk("bp_e3_rdy", {60'd0, wb_rdy}, 64'b1011);
        tick();
        chk("bp_e4_dst", {59'd0, rf_dst}, 64'(bp_exp[3]));
        chk("bp_e4_data", {32'd0, rf_wdata}, 64'(dat(5'd10)));
        chk("bp_e4_rdy", {60'd0, wb_rdy}, 64'b1111);
        tick();
        wb_v = '0;
        chk("bp_e5_dst", {59'd0, rf_dst}, 64'(bp_exp[4]));
        chk("bp_e5_rdy", {60'd0, wb_rdy}, 64'b1011);
        for (int i = 5; i < 9; i++) begin
            tick();
            chk("bp_we", {63'd0, rf_we}, 64'd1);
            chk("bp_dst", {59'd0, rf_dst}, 64'(bp_exp[i]));
            chk("bp_data", {32'd0, rf_wdata}, 64'(dat(bp_exp[i])));
        end
        tick();
        chk("bp_done_we", {63'd0, rf_we}, 64'd0);
        chk("bp_ovf", {62'd0, ovf_err}, 64'd0);

        // EX overflow, rr_ptr = 3.
        drive(0, 5'd15, dat(5'd15));
        drive(1, 5'd16, dat(5'd16));
        drive(2, 5'd17, dat(5'd17));
        drive(3, 5'd18, dat(5'd18));
        tick();
        wb_v = '0;
        drive(1, 5'd19, dat(5'd19));
        tick();
        wb_v = '0;
        chk("ovf_e1_dst", {59'd0, rf_dst}, 64'd18);
        chk("ovf_e1_rdy", {60'd0, wb_rdy}, 64'b1101);
        chk("ovf_e1_flag", {62'd0, ovf_err}, 64'd0);
        drive(1, 5'd21, dat(5'd21));
        tick();
        wb_v = '0;
        chk("ovf_e2_dst", {59'd0, rf_dst}, 64'd15);
        chk("ovf_e2_flag", {62'd0, ovf_err}, 64'b10);
        chk("ovf_e2_pend", {32'd0, pend_mask}, 64'h000B_8000);
        tick();
        chk("ovf_e3_dst", {59'd0, rf_dst}, 64'd16);
        tick();
        chk("ovf_e4_dst", {59'd0, rf_dst}, 64'd17);
        tick();
        chk("ovf_e5_dst", {59'd0, rf_dst}, 64'd19);
        tick();
        chk("ovf_e6_we", {63'd0, rf_we}, 64'd0);
        chk("ovf_sticky", {62'd0, ovf_err}, 64'b10);

        // x0 write from IDU is swallowed.
        drive(0, 5'd0, 32'h1234_5678);
        #1;
        chk("x0_rdy_pre", {60'd0, wb_rdy}, 64'hF);
        tick();
        wb_v = '0;
        chk("x0_rdy", {60'd0, wb_rdy}, 64'hF);
        chk("x0_busy", {63'd0, busy}, 64'd0);
        chk("x0_pend", {32'd0, pend_mask}, 64'd0);
        tick();
        chk("x0_we", {63'd0, rf_we}, 64'd0);
        chk("x0_busy2", {63'd0, busy}, 64'd0);
        chk("x0_ovf", {62'd0, ovf_err}, 64'b10);

        // Asynchronous reset with queued work, rr_ptr = 2.
        for (int s = 0; s < 4; s++) drive(s, 5'(s + 1), dat(5'(s + 1)));
        tick();
        wb_v = '0;
        drive(1, 5'd5, dat(5'd5));
        drive(2, 5'd6, dat(5'd6));
        tick();
        wb_v = '0;
        chk("arst_pre_dst", {59'd0, rf_dst}, 64'd3);
        chk("arst_pre_pend", {32'd0, pend_mask}, 64'h7E);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_we", {63'd0, rf_we}, 64'd0);
        chk("arst_pend", {32'd0, pend_mask}, 64'd0);
        chk("arst_rdy", {60'd0, wb_rdy}, 64'hF);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_ovf", {62'd0, ovf_err}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst_post_we", {63'd0, rf_we}, 64'd0);
            chk("arst_post_busy", {63'd0, busy}, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
